ex_operand_stage: RTL

ID/EX pipeline register and operand-select stage for the MIPS III pipeline. Captures decoded instruction fields from decode, resolves RAW hazards by forwarding from MEM and WB, and drives the ALU's A, B and F inputs directly. Detects load-use hazards and inserts a bubble into EX while requesting an upstream stall.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/fwd_mux.sv | 36 +++
 rtl/ex_operand_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types: ALU function codes and the EX-slot control bundle.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_AND     = 3'b000,
        ALU_OR      = 3'b001,
        ALU_ADD     = 3'b010,
        ALU_AND_NOT = 3'b100,
        ALU_OR_NOT  = 3'b101,
        ALU_SUB     = 3'b110,
        ALU_SLT     = 3'b111
    } alu_f_t;

    typedef struct packed {
        logic   valid;
        logic   alu_src;
        alu_f_t f;
        logic   reg_write;
        logic   mem_read;
    } ex_fields_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam ex_fields_t EX_FIELDS_RST = '{
        valid:     1'b0,
        alu_src:   1'b0,
        f:         ALU_AND,
        reg_write: 1'b0,
        mem_read:  1'b0
    };

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: MEM result beats WB result beats register data.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] src,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             mem_reg_write,
    input  logic [RADDR-1:0] mem_rd,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_reg_write,
    input  logic [RADDR-1:0] wb_rd,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] data
);

    logic src_nz;
    logic mem_hit;
    logic wb_hit;

    assign src_nz  = (src != RADDR'(REG_ZERO));
    assign mem_hit = mem_reg_write && (mem_rd == src) && src_nz;
    assign wb_hit  = wb_reg_write && (wb_rd == src) && src_nz;

    always_comb begin
        data = reg_data;
        if (mem_hit) begin
            data = mem_result;
        end else if (wb_hit) begin
            data = wb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand forwarding and load-use bubble insertion.
// Define EX_FORWARD_EN to build the MEM/WB bypass; otherwise stall on hazards.
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_alu_src,
    input  logic [2:0]       id_alu_f,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_reg_write,
    input  logic [RADDR-1:0] mem_rd,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_reg_write,
    input  logic [RADDR-1:0] wb_rd,
    input  logic [WIDTH-1:0] wb_result,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [2:0]       ex_f,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             load_use_stall
);

    ex_fields_t       ctrl_q, ctrl_d;
    logic [RADDR-1:0] rs_q, rs_d;
    logic [RADDR-1:0] rt_q, rt_d;
    logic [RADDR-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] rs_data_q, rs_data_d;
    logic [WIDTH-1:0] rt_data_q, rt_data_d;
    logic [WIDTH-1:0] imm_q, imm_d;

    logic [WIDTH-1:0] op_rs;
    logic [WIDTH-1:0] op_rt;
    logic             id_dep_ex;

    assign id_dep_ex = (rd_q != RADDR'(REG_ZERO))
                    && ((rd_q == id_rs) || (rd_q == id_rt));

`ifdef EX_FORWARD_EN
    fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs (
        .src           (rs_q),
        .reg_data      (rs_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .data          (op_rs)
    );

    fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rt (
        .src           (rt_q),
        .reg_data      (rt_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .data          (op_rt)
    );

    assign load_use_stall = ex_valid && ex_mem_read && id_valid && id_dep_ex;
`else
    logic id_dep_mem;
    logic unused_fwd;

    assign op_rs = rs_data_q;
    assign op_rt = rt_data_q;

    // WB writer is covered by the write-first register file.
    assign id_dep_mem = mem_reg_write
                     && (mem_rd != RADDR'(REG_ZERO))
                     && ((mem_rd == id_rs) || (mem_rd == id_rt));

    assign load_use_stall = id_valid
                         && ((ex_reg_write && id_dep_ex) || id_dep_mem);

    assign unused_fwd = ^{mem_result, wb_reg_write, wb_rd, wb_result,
                          rs_q, rt_q};
`endif

    always_comb begin
        ctrl_d    = ctrl_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        if (flush) begin
            ctrl_d.valid = 1'b0;
        end else if (!stall) begin
            if (load_use_stall) begin
                ctrl_d.valid = 1'b0;
            end else begin
                ctrl_d.valid     = id_valid;
                ctrl_d.alu_src   = id_alu_src;
                ctrl_d.f         = alu_f_t'(id_alu_f);
                ctrl_d.reg_write = id_reg_write;
                ctrl_d.mem_read  = id_mem_read;
                rs_d             = id_rs;
                rt_d             = id_rt;
                rd_d             = id_rd;
                rs_data_d        = id_rs_data;
                rt_data_d        = id_rt_data;
                imm_d            = id_imm;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q    <= EX_FIELDS_RST;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_f          = ctrl_q.f;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = ctrl_q.valid && ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.valid && ctrl_q.mem_read;
    assign ex_a          = op_rs;
    assign ex_b          = ctrl_q.alu_src ? imm_q : op_rt;
    assign ex_store_data = op_rt;

endmodule
